// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module : bcd_pkg
// Brief  : Shared FSM encoding, segment patterns and sizing helper for the
//          sequential binary-to-BCD display converter.
// Rev    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Segment vectors are ordered bit6=g .. bit0=a, active-low.
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;
    localparam logic [6:0] SEG_DASH  = 7'b011_1111;

    function automatic logic [6:0] seg_lut(input logic [3:0] digit);
        logic [6:0] w_seg;
        case (digit)
            4'd0:    w_seg = 7'b100_0000;
            4'd1:    w_seg = 7'b111_1001;
            4'd2:    w_seg = 7'b010_0100;
            4'd3:    w_seg = 7'b011_0000;
            4'd4:    w_seg = 7'b001_1001;
            4'd5:    w_seg = 7'b001_0010;
            4'd6:    w_seg = 7'b000_0010;
            4'd7:    w_seg = 7'b111_1000;
            4'd8:    w_seg = 7'b000_0000;
            4'd9:    w_seg = 7'b001_0000;
            default: w_seg = SEG_BLANK;
        endcase
        return w_seg;
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_encode.sv
`default_nettype none
// ============================================================================
// Module : seg7_encode
// Brief  : One BCD digit plus blank flag to active-low seven-segment pattern.
// Rev    : 1.0 - initial release
// ============================================================================
module seg7_encode
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = i_blank ? SEG_BLANK : seg_lut(i_digit);
    end

endmodule
`default_nettype wire

// File: rtl/bcd_seq_converter.sv
`default_nettype none
// ============================================================================
// Module : bcd_seq_converter
// Brief  : Double-dabble binary-to-BCD converter (one bit per clock) driving
//          DIGITS active-low seven-segment displays with blanking and overflow.
// Rev    : 1.0 - initial release
// ============================================================================
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int IN     = 10,
    parameter int DIGITS = 4,
    parameter int S      = 7,
    parameter int BLANK  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN-1:0]         bin,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [S*DIGITS-1:0]   hex
);

    localparam int CW = cnt_width(IN);
    localparam int BW = 4 * DIGITS;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IN-1:0]           r_shreg;
    logic [BW-1:0]           r_scratch;
    logic [BW-1:0]           w_adj;
    logic                    r_ovf_s;
    logic [CW-1:0]           r_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_ovf;
    logic [BW-1:0]           r_bcd;
    logic [S*DIGITS-1:0]     r_hex;
    logic [S*DIGITS-1:0]     w_hex;
    logic [DIGITS-1:0]       w_lead;
    logic [DIGITS-1:0]       w_blank;
    logic                    w_run;
    logic [DIGITS-1:0][6:0]  w_seg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (r_cnt == CW'(1)) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Add-3 correction applied to every nibble before the shift.
    always_comb begin
        w_adj = r_scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_scratch[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg   <= '0;
            r_scratch <= '0;
            r_ovf_s   <= 1'b0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_bcd     <= '0;
            r_hex     <= '1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_shreg   <= bin;
                        r_scratch <= '0;
                        r_ovf_s   <= 1'b0;
                        r_cnt     <= CW'(IN);
                        r_busy    <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_scratch <= {w_adj[BW-2:0], r_shreg[IN-1]};
                    r_shreg   <= r_shreg << 1;
                    r_ovf_s   <= r_ovf_s | w_adj[BW-1];
                    r_cnt     <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_busy <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_bcd  <= r_scratch;
                    r_ovf  <= r_ovf_s;
                    r_hex  <= w_hex;
                    r_done <= 1'b1;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    // A digit above the units is a leading zero when it and everything above it is zero.
    always_comb begin
        w_lead = '0;
        w_run  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_run     = w_run & (r_scratch[4*k +: 4] == 4'd0);
            w_lead[k] = w_run;
        end
        w_blank = (BLANK != 0) ? w_lead : '0;
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        seg7_encode u_seg (
            .i_digit (r_scratch[4*k +: 4]),
            .i_blank (w_blank[k]),
            .o_seg   (w_seg[k])
        );
    end

    always_comb begin
        w_hex = '1;
        for (int k = 0; k < DIGITS; k++) begin
            w_hex[S*k +: 7] = r_ovf_s ? SEG_DASH : w_seg[k];
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign ovf  = r_ovf;
    assign bcd  = r_bcd;
    assign hex  = r_hex;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seq_converter.sv
`default_nettype none
// ============================================================================
// Module : tb_bcd_seq_converter
// Brief  : Self-checking bench for bcd_seq_converter (default, IN=14, BLANK=0).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_bcd_seq_converter;

    typedef struct {
        int          sel;
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic [27:0] hex;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       start_v = '0;
    logic [2:0][13:0] bin_v = '0;
    logic [2:0]       busy_v;
    logic [2:0]       done_v;
    logic [2:0]       ovf_v;
    logic [2:0][15:0] bcd_v;
    logic [2:0][27:0] hex_v;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bcd_seq_converter #(.IN(10), .DIGITS(4), .S(7), .BLANK(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .bin(bin_v[0][9:0]),
        .busy(busy_v[0]), .done(done_v[0]), .ovf(ovf_v[0]), .bcd(bcd_v[0]), .hex(hex_v[0])
    );

    bcd_seq_converter #(.IN(14), .DIGITS(4), .S(7), .BLANK(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .bin(bin_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .ovf(ovf_v[1]), .bcd(bcd_v[1]), .hex(hex_v[1])
    );

    bcd_seq_converter #(.IN(10), .DIGITS(4), .S(7), .BLANK(0)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .bin(bin_v[2][9:0]),
        .busy(busy_v[2]), .done(done_v[2]), .ovf(ovf_v[2]), .bcd(bcd_v[2]), .hex(hex_v[2])
    );

    // Segment strings written a..g left to right; the port wants a at bit 0.
    function automatic logic [6:0] spec_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] rev7(input logic [6:0] x);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) r[i] = x[6-i];
        return r;
    endfunction

    function automatic logic [27:0] model_hex(input logic [15:0] b, input logic o, input bit blank);
        logic [27:0] h;
        bit          zero_above;
        logic [3:0]  d;
        h = '1;
        zero_above = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            d = b[4*k +: 4];
            zero_above = zero_above && (d == 4'd0);
            if (o)                               h[7*k +: 7] = rev7(7'b1111110);
            else if (blank && k > 0 && zero_above) h[7*k +: 7] = rev7(7'b1111111);
            else                                 h[7*k +: 7] = rev7(spec_seg(d));
        end
        return h;
    endfunction

    function automatic int in_width(input int sel);
        return (sel == 1) ? 14 : 10;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive one conversion, push its expectation, then wait for done and score it.
    // pa/pb: cycle offsets after accept at which start is re-asserted (0 = none).
    task automatic convert(input int sel, input logic [13:0] val, input logic [15:0] eb,
                           input logic eo, input int pa, input int pb, input string tag);
        exp_t e;
        int   lat;
        int   nbusy;
        bit   got;
        e.bcd = eb;
        e.ovf = eo;
        e.hex = model_hex(eb, eo, sel != 2);
        sbq.push_back(e);
        @(negedge clk);
        bin_v[sel]   = val;
        start_v[sel] = 1'b1;
        @(negedge clk);
        bin_v[sel] = ~val;
        lat = 0;
        nbusy = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            start_v[sel] = (lat + 1 == pa) || (lat + 1 == pb);
            if (done_v[sel]) begin
                got = 1'b1;
            end else begin
                if (busy_v[sel]) nbusy++;
                @(negedge clk);
                lat++;
            end
        end
        start_v[sel] = 1'b0;
        check({tag, "_latency"}, lat, in_width(sel) + 1);
        check({tag, "_busy_cycles"}, nbusy, in_width(sel));
        if (sbq.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 1, 0);
        end else begin
            e = sbq.pop_front();
            check({tag, "_bcd"}, bcd_v[sel], e.bcd);
            check({tag, "_ovf"}, ovf_v[sel], e.ovf);
            check({tag, "_hex"}, hex_v[sel], e.hex);
        end
        @(negedge clk);
        check({tag, "_done_pulse_width"}, done_v[sel], 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        int   ndone;

        vecs[0] = '{0, 14'd1,     16'h0001, 1'b0};
        vecs[1] = '{0, 14'd152,   16'h0152, 1'b0};
        vecs[2] = '{0, 14'd1023,  16'h1023, 1'b0};
        vecs[3] = '{0, 14'd0,     16'h0000, 1'b0};
        vecs[4] = '{2, 14'd0,     16'h0000, 1'b0};
        vecs[5] = '{1, 14'd10000, 16'h0000, 1'b1};
        vecs[6] = '{1, 14'd9999,  16'h9999, 1'b0};
        vecs[7] = '{1, 14'd16383, 16'h6383, 1'b1};
        vecs[8] = '{0, 14'd100,   16'h0100, 1'b0};
        vecs[9] = '{2, 14'd7,     16'h0007, 1'b0};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset%0d_busy", d), busy_v[d], 0);
            check($sformatf("reset%0d_done", d), done_v[d], 0);
            check($sformatf("reset%0d_ovf", d),  ovf_v[d], 0);
            check($sformatf("reset%0d_bcd", d),  bcd_v[d], 0);
            check($sformatf("reset%0d_hex", d),  hex_v[d], 28'hfffffff);
        end
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].sel, vecs[i].bin, vecs[i].bcd, vecs[i].ovf, 0, 0,
                    $sformatf("vec%0d", i));
        end

        // start re-asserted mid-shift and in DONE: neither may be accepted.
        convert(0, 14'd20, 16'h0020, 1'b0, 3, 11, "ignore_start");
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done_v[0]) ndone++;
        end
        check("ignore_start_extra_done", ndone, 0);
        check("ignore_start_hold_bcd", bcd_v[0], 16'h0020);

        // Asynchronous reset five cycles into a conversion of 100.
        @(negedge clk);
        bin_v[0]   = 14'd100;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", busy_v[0], 1);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", busy_v[0], 0);
        check("abort_bcd",  bcd_v[0], 0);
        check("abort_hex",  hex_v[0], 28'hfffffff);
        check("abort_ovf",  ovf_v[0], 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_v[0]) ndone++;
        end
        check("abort_no_done", ndone, 0);

        convert(0, 14'd100, 16'h0100, 1'b0, 0, 0, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
